// File: rtl/qoi_enc_stream_if.sv
// qoi_enc_stream_if: pixel input and encoded byte output handshakes of qoi_enc_stream.
interface qoi_enc_stream_if;
    logic        px_valid;
    logic        px_ready;
    logic [31:0] px_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    modport master (output px_valid, px_data, out_ready, input px_ready, out_valid, out_data, out_last);
    modport slave (input px_valid, px_data, out_ready, output px_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/qoi_enc_stream.sv
// qoi_enc_stream: streaming QOI encoder, RGBA pixels in, encoded bytes out through a byte FIFO.
// Define QOI_END_MARKER_EN to append the 8-byte QOI end marker to every frame.
module qoi_enc_stream #(
    parameter int COUNT_W = 30,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] size,
    qoi_enc_stream_if.slave    bus,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] pixel_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [2:0] {IDLE, ACCEPT, CLASSIFY, EMIT, FLUSH, TAIL} state_t;
    state_t state;
    logic [COUNT_W-1:0] size_r;
    logic [31:0] px, prev;
    logic [31:0] tbl [64];
    logic [63:0] tbl_v;
    logic [5:0] run, hash;
    logic [47:0] q, nq;
    logic [2:0] q_n, nq_n, ob_n;
    logic [39:0] ob;
    logic [8:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic full, push, pop, push_req, push_last, last_px, drained, same_a, hit, is_diff, is_luma;
    logic [7:0] push_data, r, g, b, a, vr, vg, vb, dr2, dg2, db2, vg32, vrg8, vbg8, rb_res;
    assign {a, b, g, r} = px;
    assign vr = r - prev[7:0];
    assign vg = g - prev[15:8];
    assign vb = b - prev[23:16];
    assign same_a = a == prev[31:24];
    // Only the low 6 bits of each product survive the mod 64
    assign hash = r[5:0] * 6'd3 + g[5:0] * 6'd5 + b[5:0] * 6'd7 + a[5:0] * 6'd11;
    assign dr2 = vr + 8'd2;
    assign dg2 = vg + 8'd2;
    assign db2 = vb + 8'd2;
    assign vg32 = vg + 8'd32;
    assign vrg8 = vr - vg + 8'd8;
    assign vbg8 = vb - vg + 8'd8;
    assign hit = (tbl_v[hash] ? tbl[hash] : 32'd0) == px;
    assign is_diff = same_a && dr2 < 8'd4 && dg2 < 8'd4 && db2 < 8'd4;
    assign is_luma = same_a && vg32 < 8'd64 && vrg8 < 8'd16 && vbg8 < 8'd16;
    assign ob = hit ? {2'b00, hash, 32'd0}
              : is_diff ? {2'b01, dr2[1:0], dg2[1:0], db2[1:0], 32'd0}
              : is_luma ? {2'b10, vg32[5:0], vrg8[3:0], vbg8[3:0], 24'd0}
              : {same_a ? 8'hFE : 8'hFF, r, g, b, a};
    assign ob_n = hit || is_diff ? 3'd1 : is_luma ? 3'd2 : same_a ? 3'd4 : 3'd5;
    assign nq = run != '0 ? {2'b11, run - 6'd1, ob} : {ob, 8'd0};
    assign nq_n = ob_n + {2'b00, run != '0};
    assign rb_res = {2'b11, run - 6'd1};
    assign last_px = pixel_count == size_r;
    assign full = cnt == CW'(FIFO_DEPTH);
    assign push = push_req && !full;
    assign pop = bus.out_valid && bus.out_ready;
    assign bus.out_valid = cnt != '0;
    assign {bus.out_last, bus.out_data} = bus.out_valid ? mem[rp] : 9'd0;
    assign bus.px_ready = state == ACCEPT;
`ifdef QOI_END_MARKER_EN
    logic [3:0] tail_i;
    assign push_req = state == EMIT || (state == FLUSH && run != '0) || (state == TAIL && !tail_i[3]);
    assign push_data = state == TAIL ? {7'd0, tail_i == 4'd7} : state == FLUSH ? rb_res : q[47:40];
    assign push_last = state == TAIL && tail_i == 4'd7;
    assign drained = tail_i[3] && (cnt == '0 || (cnt == CW'(1) && pop));
`else
    assign push_req = state == EMIT || (state == FLUSH && run != '0);
    assign push_data = state == FLUSH ? rb_res : q[47:40];
    assign push_last = state == FLUSH || (q_n == 3'd1 && last_px);
    assign drained = cnt == '0 || (cnt == CW'(1) && pop);
`endif
    always_ff @(posedge clk) if (push) mem[wp] <= {push_last, push_data};
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            pixel_count <= '0;
            cnt <= '0;
            wp <= '0;
            rp <= '0;
            run <= '0;
            q_n <= '0;
            tbl_v <= '0;
`ifdef QOI_END_MARKER_EN
            tail_i <= '0;
`endif
        end else begin
            done <= 1'b0;
            cnt <= cnt + CW'(push) - CW'(pop);
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            case (state)
                IDLE: if (start) begin
                    size_r <= size;
                    pixel_count <= '0;
                    run <= '0;
                    prev <= 32'hFF00_0000;
                    tbl_v <= '0;
`ifdef QOI_END_MARKER_EN
                    tail_i <= '0;
                    busy <= 1'b1;
                    state <= size == '0 ? TAIL : ACCEPT;
`else
                    // An empty frame has nothing to drain, so it completes straight away
                    busy <= size != '0;
                    done <= size == '0;
                    state <= size == '0 ? IDLE : ACCEPT;
`endif
                end
                ACCEPT: if (bus.px_valid) begin
                    px <= bus.px_data;
                    pixel_count <= pixel_count + COUNT_W'(1);
                    state <= CLASSIFY;
                end
                CLASSIFY: if (px == prev) begin
                    run <= run == 6'd61 || last_px ? '0 : run + 6'd1;
                    q <= {2'b11, run, 40'd0};
                    q_n <= 3'd1;
                    state <= run == 6'd61 || last_px ? EMIT : ACCEPT;
                end else begin
                    run <= '0;
                    q <= nq;
                    q_n <= nq_n;
                    prev <= px;
                    tbl[hash] <= px;
                    tbl_v[hash] <= 1'b1;
                    state <= EMIT;
                end
                EMIT: if (!full) begin
                    q <= q << 8;
                    q_n <= q_n - 3'd1;
                    if (q_n == 3'd1) state <= last_px ? FLUSH : ACCEPT;
                end
                FLUSH: if (run == '0) state <= TAIL; else if (!full) run <= '0;
                TAIL: begin
`ifdef QOI_END_MARKER_EN
                    tail_i <= tail_i + 4'(push);
`endif
                    if (drained) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qoi_enc_stream.sv
// tb_qoi_enc_stream: directed vector bench for qoi_enc_stream; expected streams follow QOI_END_MARKER_EN.
module tb_qoi_enc_stream;
    localparam int CW = 30;
    typedef struct {
        int n;
        logic [95:0] pxs;
        int nb;
        logic [79:0] obs;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [CW-1:0] size = '0;
    logic busy, done;
    logic [CW-1:0] pixel_count;
    int n_cmp = 0, n_bad = 0, last_done_cyc = -1;
    logic [31:0] pix_q [$];
    logic [7:0] exp_q [$];
    vec_t vecs [10];
    qoi_enc_stream_if bus ();
    qoi_enc_stream #(.COUNT_W(CW), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .size(size), .bus(bus),
        .busy(busy), .done(done), .pixel_count(pixel_count)
    );
    always #5 clk = ~clk;
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    function automatic logic [31:0] pxl(input int r, input int g, input int b, input int a);
        return {8'(a), 8'(b), 8'(g), 8'(r)};
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic add_marker();
`ifdef QOI_END_MARKER_EN
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
`endif
    endtask
    task automatic load(input vec_t v);
        pix_q.delete();
        exp_q.delete();
        for (int i = 0; i < v.n; i++) pix_q.push_back(v.pxs[95 - 32 * (i < 3 ? i : 2) -: 32]);
        for (int i = 0; i < v.nb; i++) exp_q.push_back(v.obs[79 - 8 * i -: 8]);
        add_marker();
    endtask
    task automatic check_reset(input string nm);
        chk({nm, " px_ready"}, 32'(bus.px_ready), 0);
        chk({nm, " out_valid"}, 32'(bus.out_valid), 0);
        chk({nm, " out_data"}, 32'(bus.out_data), 0);
        chk({nm, " out_last"}, 32'(bus.out_last), 0);
        chk({nm, " busy"}, 32'(busy), 0);
        chk({nm, " done"}, 32'(done), 0);
        chk({nm, " pixel_count"}, 32'(pixel_count), 0);
    endtask
    task automatic run_frame(input string nm, input int stall_len, input int start_glitch);
        logic [7:0] rx [$];
        int pi = 0, cyc = 0, dones = 0, done_cyc = -1, lasts = 0, last_pos = -1, post = 0, extra_rdy = 0, stall_bad = 0;
        @(posedge clk); #1;
        start = 1'b1;
        size = CW'(pix_q.size());
        @(posedge clk); #1;
        start = 1'b0;
        while (post < 3 && cyc < 4000) begin
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (dones > 0) post++;
            start = cyc == start_glitch;
            if (start) size = CW'(1);
            bus.out_ready = cyc >= stall_len;
            bus.px_valid = pi < pix_q.size() && $urandom_range(3) != 0;
            bus.px_data = pi < pix_q.size() ? pix_q[pi] : 32'h0;
            if (bus.px_ready && pi == pix_q.size()) extra_rdy++;
            if (cyc >= 30 && cyc < stall_len && (bus.px_ready || !bus.out_valid || bus.out_data !== exp_q[0])) stall_bad++;
            if (bus.px_valid && bus.px_ready) pi++;
            if (bus.out_valid && bus.out_ready) begin
                rx.push_back(bus.out_data);
                if (bus.out_last) begin
                    lasts++;
                    last_pos = rx.size() - 1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        bus.px_valid = 1'b0;
        bus.out_ready = 1'b1;
        last_done_cyc = done_cyc;
        chk({nm, " in_time"}, 32'(cyc < 4000), 1);
        chk({nm, " nbytes"}, rx.size(), exp_q.size());
        for (int i = 0; i < rx.size() && i < exp_q.size(); i++) chk($sformatf("%s byte%0d", nm, i), rx[i], exp_q[i]);
        chk({nm, " last_count"}, lasts, exp_q.size() > 0 ? 1 : 0);
        if (exp_q.size() > 0) chk({nm, " last_pos"}, last_pos, exp_q.size() - 1);
        chk({nm, " done_count"}, dones, 1);
        chk({nm, " busy_after"}, 32'(busy), 0);
        chk({nm, " px_ready_extra"}, extra_rdy, 0);
        chk({nm, " pixel_count"}, 32'(pixel_count), pix_q.size());
        if (stall_len > 30) chk({nm, " stall_hold"}, stall_bad, 0);
    endtask
    initial begin
        logic [31:0] pa, pb, pk;
        string names [10];
        pa = pxl(10, 20, 30, 255);
        pb = pxl(200, 0, 0, 255);
        pk = pxl(0, 0, 0, 255);
        vecs[0] = '{1, {pk, 64'd0}, 1, {8'hC0, 72'd0}};
        vecs[1] = '{2, {pa, pxl(11, 20, 29, 255), 32'd0}, 5, {8'hFE, 8'h0A, 8'h14, 8'h1E, 8'h79, 40'd0}};
        vecs[2] = '{2, {pa, pxl(20, 30, 40, 255), 32'd0}, 6, {8'hFE, 8'h0A, 8'h14, 8'h1E, 8'hAA, 8'h88, 32'd0}};
        vecs[3] = '{3, {pa, pb, pa}, 9, {8'hFE, 8'h0A, 8'h14, 8'h1E, 8'hFE, 8'hC8, 8'h00, 8'h00, 8'h09, 8'd0}};
        vecs[4] = '{1, {pxl(1, 2, 3, 4), 64'd0}, 5, {8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 40'd0}};
        vecs[5] = '{64, {pk, pk, pk}, 2, {8'hFD, 8'hC1, 64'd0}};
        vecs[6] = '{3, {pk, pk, pxl(1, 1, 1, 255)}, 2, {8'hC1, 8'h7F, 64'd0}};
        vecs[7] = '{1, {pxl(255, 0, 1, 255), 64'd0}, 1, {8'h5B, 72'd0}};
        vecs[8] = '{1, {pxl(0, 0, 0, 0), 64'd0}, 1, {8'h00, 72'd0}};
        vecs[9] = '{0, 96'd0, 0, 80'd0};
        names = '{"run1", "rgb_diff", "luma", "index", "rgba", "run_split", "run_then_diff", "diff_wrap", "index_zero", "zero_size"};
        bus.px_valid = 1'b0;
        bus.px_data = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            load(vecs[k]);
            run_frame(names[k], 0, -1);
        end
`ifndef QOI_END_MARKER_EN
        chk("zero_size done_latency", last_done_cyc, 0);
`endif
        pix_q.delete();
        exp_q.delete();
        for (int k = 1; k <= 6; k++) begin
            pix_q.push_back(pxl(k, 2 * k, 3 * k, k));
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'(k));
            exp_q.push_back(8'(2 * k));
            exp_q.push_back(8'(3 * k));
            exp_q.push_back(8'(k));
        end
        add_marker();
        run_frame("backpressure", 40, 10);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        start = 1'b1;
        size = CW'(4);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 14; c++) begin
            bus.px_valid = 1'b1;
            bus.px_data = c[0] ? pb : pa;
            @(posedge clk); #1;
        end
        chk("abort busy_before", 32'(busy), 1);
        bus.px_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("abort");
        rst = 1'b0;
        bus.out_ready = 1'b1;
        pix_q.delete();
        exp_q.delete();
        pix_q.push_back(pa);
        exp_q = '{8'hFE, 8'h0A, 8'h14, 8'h1E};
        add_marker();
        run_frame("after_abort", 0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/qoi_enc_stream.md
# qoi_enc_stream

Streaming, parametrised QOI encoder. It accepts RGBA pixels over a valid/ready input and emits the encoded QOI byte stream over a valid/ready output through an internal byte FIFO. It sits between a pixel source and the bus-facing buffer in the accelerator. Unlike the shared-RAM encoder, it has no CPU read/write windows, and it supports backpressure, full QOI op priority and an optional end marker.

## Interface
- `COUNT_W`, default 30: width of the pixel-count fields.
- `FIFO_DEPTH`, default 8: output byte FIFO depth; must be a power of 2 and at least 8.
- `clk` (in, 1): clock.
- `rst` (in, 1): reset, synchronous, active-high.
- `start` (in, 1): one-cycle pulse that latches `size` and begins a frame. Ignored while `busy`.
- `size` (in, `COUNT_W`): number of pixels in the frame.
- `px_valid` (in, 1): pixel handshake, valid.
- `px_ready` (out, 1): pixel handshake, ready.
- `px_data` (in, 32): pixel; [7:0]=r, [15:8]=g, [23:16]=b, [31:24]=a.
- `out_valid` (out, 1): output byte handshake, valid.
- `out_ready` (in, 1): output byte handshake, ready.
- `out_data` (out, 8): encoded byte.
- `out_last` (out, 1): high with the final byte of the frame.
- `busy` (out, 1): high from `start` until the final byte is popped.
- `done` (out, 1): one-cycle pulse when the final byte is popped.
- `pixel_count` (out, `COUNT_W`): number of pixels accepted in the current frame.

## Operation
- **States:** IDLE, ACCEPT, CLASSIFY, EMIT, FLUSH, TAIL.
- **IDLE → ACCEPT on `start`.**
  - Latches `size`.
  - Clears `pixel_count` and `run`.
  - Sets `prev` = (0,0,0,255).
  - Invalidates all 64 index entries in one cycle via a valid-bit vector; an invalid entry reads as 0.
- **Zero size:** if `size`==0 the block goes IDLE → TAIL.
- **ACCEPT:** `px_ready`=1. On handshake the block registers `px`, increments `pixel_count` and goes to CLASSIFY.
- **CLASSIFY:** selects ops in this order.
  - `px`==`prev` → `run`++. If `run` reaches 62, or this is the last pixel, queue RUN (0xC0|(run-1)) and clear `run`. Otherwise return to ACCEPT with no output.
  - Otherwise, if `run`>0, queue RUN first, then the pixel op.
  - Pixel op, first match wins:
    - INDEX if `table[hash]`==`px`: 1 byte, hash.
    - DIFF if vr, vg, vb are all in [-2,1] and alpha is unchanged: 0x40|(vr+2)<<4|(vg+2)<<2|(vb+2).
    - LUMA if vg is in [-32,31], vr-vg and vb-vg are in [-8,7], and alpha is unchanged: 0x80|(vg+32), then (vr-vg+8)<<4|(vb-vg+8).
    - RGB if alpha is unchanged: FE r g b.
    - RGBA otherwise: FF r g b a.
- **Arithmetic:**
  - `hash` = (r·3+g·5+b·7+a·11) mod 64.
  - Differences are computed mod 256, then interpreted as signed 8-bit (wrap per QOI).
- **Table update:** after every non-run pixel, `table[hash]`=`px` and `prev`=`px`.
- **EMIT:** pushes queued bytes, at most one per cycle, only when the FIFO is not full. It stalls otherwise; no byte is dropped or reordered.
  - When the queue is empty and pixels remain, go to ACCEPT.
  - When the queue is empty after the last pixel, go to FLUSH.
- **FLUSH:** pushes any residual RUN byte, then goes to TAIL.
- **TAIL:** pushes the end marker (see Configuration) and waits for the FIFO to drain. When the last byte pops: `done` pulses, `busy` drops, state returns to IDLE.

## Timing
- Reset values: `px_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0, `pixel_count`=0. The FIFO is emptied and the state is IDLE.
- Pixel handshake occurs in cycle N. Classification completes at N+1. The first byte is pushed at N+2 and `out_valid` rises at N+3 if the FIFO was empty.
- `out_valid` = FIFO not empty. While `out_valid` && !`out_ready`, `out_data` and `out_last` hold stable.
- Pop occurs on `out_valid` && `out_ready`.
- With the FIFO full, a simultaneous pop and push is blocked: full is evaluated before the pop, so the push waits one cycle.
- `px_ready` is never high outside ACCEPT.
- Peak rate is one pixel per 3 cycles for 1-byte ops.
- `rst` asserted mid-frame aborts the frame in the next cycle. No `done` pulse is produced and queued bytes are discarded.
- `start` pulses while `busy` have no effect.

## Configuration
- `QOI_END_MARKER_EN` defined: TAIL pushes 00 00 00 00 00 00 00 01, and `out_last` accompanies the 0x01 byte.
- `QOI_END_MARKER_EN` undefined: TAIL pushes nothing, and `out_last` accompanies the final op byte. With `size`==0, `done` pulses one cycle after `start` and no bytes are emitted.

## Test plan
All scenarios have `QOI_END_MARKER_EN` defined unless stated.
- **Single pixel, run:** `size`=1, pixel (0,0,0,255) → C0 00 00 00 00 00 00 00 01, `out_last` on 01, `done` pulses once.
- **RGB then DIFF:** `size`=2, pixels (10,20,30,255) then (11,20,29,255) → FE 0A 14 1E 79, then the marker.
- **LUMA:** `size`=2, pixels (10,20,30,255) then (20,30,40,255) → FE 0A 14 1E AA 88.
- **INDEX and RGBA:**
  - `size`=3, pixels A=(10,20,30,255), B=(200,0,0,255), A → FE 0A 14 1E, FE C8 00 00, 09.
  - Then a separate frame, `size`=1, pixel (1,2,3,4) → FF 01 02 03 04.
- **Run split:** `size`=64, all pixels (0,0,0,255) → FD C1, then the marker.
- **Backpressure and reset:**
  - `FIFO_DEPTH`=8, `out_ready`=0 for 40 cycles during an RGBA-heavy frame → `px_ready` falls once 8 bytes are held and `out_data` stays stable; after release the byte stream matches the unstalled golden stream.
  - `rst` asserted mid-frame → all outputs return to reset values the next cycle; a following frame encodes correctly with a cleared index table.
